// File: rtl/gru_pkg.sv
// Shared definitions for the GRU candidate-state MAC block.
// Build option: GRU_CAND_SAT_EN selects saturating (defined) or wrapping
// (undefined) narrowing in sat_narrow().
package gru_pkg;

    localparam int unsigned GRU_DATABIT = 16;
    localparam int unsigned GRU_FRACBIT = 8;

    // Q-format 1.0 at the default widths
    localparam logic [GRU_DATABIT-1:0] ONE = GRU_DATABIT'(1 << GRU_FRACBIT);

    // FSM state encoding
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MAC_X = 3'd1;
    localparam logic [2:0] S_GATE  = 3'd2;
    localparam logic [2:0] S_MAC_H = 3'd3;
    localparam logic [2:0] S_BIAS  = 3'd4;
    localparam logic [2:0] S_ACT   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    // Narrow a wide signed value to w bits; caller keeps the low w bits of the return value
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int unsigned       w);
`ifdef GRU_CAND_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/gru_tanh_pwl.sv
// Piecewise-linear tanh in signed fixed point, shifts and adds only.
module gru_tanh_pwl #(
    parameter int unsigned DATABIT = 16,
    parameter int unsigned FRACBIT = 8
) (
    input  logic [DATABIT-1:0] x,
    output logic [DATABIT-1:0] y_c
);

    localparam logic [DATABIT-1:0] Q_ONE  = DATABIT'(1 << FRACBIT);
    localparam logic [DATABIT-1:0] Q_HALF = DATABIT'(1 << (FRACBIT - 1));
    localparam logic [DATABIT-1:0] Q_QTR  = DATABIT'(1 << (FRACBIT - 2));
    localparam logic [DATABIT-1:0] Q_TWO  = DATABIT'(1 << (FRACBIT + 1));

    logic              neg;
    logic [DATABIT-1:0] mag;
    logic [DATABIT-1:0] seg;

    // Fold to magnitude (most-negative input reads as large), pick segment, restore sign
    always_comb begin
        neg = x[DATABIT-1];
        mag = neg ? (~x + DATABIT'(1)) : x;
        if (mag < Q_HALF) begin
            seg = mag;
        end else if (mag < Q_ONE) begin
            seg = (mag >> 1) + Q_QTR;
        end else if (mag < Q_TWO) begin
            seg = (mag >> 2) + Q_HALF;
        end else begin
            seg = Q_ONE;
        end
        y_c = neg ? (~seg + DATABIT'(1)) : seg;
    end

endmodule

// File: rtl/gru_cand_mac_seq.sv
// GRU candidate state h~ = tanh(Wxh.xt + Whh.(rt*ht1) + bh) for one hidden cell,
// dot products time-multiplexed over LANES multipliers.
// Build option: GRU_CAND_SAT_EN (saturating narrowing in GATE and BIAS).
module gru_cand_mac_seq
    import gru_pkg::*;
#(
    parameter int unsigned INPUTDIMEN = 4,
    parameter int unsigned CELLNUM    = 4,
    parameter int unsigned DATABIT    = GRU_DATABIT,
    parameter int unsigned FRACBIT    = GRU_FRACBIT,
    parameter int unsigned LANES      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUTDIMEN*DATABIT-1:0] xt,
    input  logic [CELLNUM*DATABIT-1:0]    ht1,
    input  logic [CELLNUM*DATABIT-1:0]    rt,
    input  logic [INPUTDIMEN*DATABIT-1:0] wxh_in,
    input  logic [CELLNUM*DATABIT-1:0]    whh_in,
    input  logic [DATABIT-1:0]            bh,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATABIT-1:0]            result
);

    localparam int unsigned NX     = INPUTDIMEN / LANES;
    localparam int unsigned NH     = CELLNUM / LANES;
    localparam int unsigned ACCBIT = 2 * DATABIT + $clog2(INPUTDIMEN + CELLNUM + 1);
    localparam int unsigned PRODW  = 2 * DATABIT;
    localparam int unsigned LW     = LANES * DATABIT;
    localparam int unsigned XW     = INPUTDIMEN * DATABIT;
    localparam int unsigned HW     = CELLNUM * DATABIT;
    localparam int unsigned CNTW   = $clog2(NX + NH + 1);

    if ((INPUTDIMEN % LANES) != 0) begin : g_bad_x
        $error("INPUTDIMEN must be a multiple of LANES");
    end
    if ((CELLNUM % LANES) != 0) begin : g_bad_h
        $error("CELLNUM must be a multiple of LANES");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_nxt;
    logic             accept;

    logic [XW-1:0]    xt_q;
    logic [XW-1:0]    wxh_q;
    logic [HW-1:0]    ht1_q;
    logic [HW-1:0]    rt_q;
    logic [HW-1:0]    whh_q;
    logic [HW-1:0]    rh_q;
    logic signed [DATABIT-1:0] bh_q;
    logic signed [ACCBIT-1:0]  acc;
    logic [DATABIT-1:0]        pre_q;

    logic signed [ACCBIT-1:0]  x_sum;
    logic signed [ACCBIT-1:0]  h_sum;
    logic [LW-1:0]             rh_lanes;
    logic signed [ACCBIT-1:0]  bias_sum;
    logic signed [ACCBIT-1:0]  bias_sh;
    logic [DATABIT-1:0]        pre_c;
    logic [DATABIT-1:0]        tanh_c;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // State and lane-group counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; cnt walks the lane groups of the multi-cycle phases
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_MAC_X;
                    cnt_nxt   = '0;
                end
            end
            S_MAC_X: begin
                if (cnt == CNTW'(NX - 1)) begin
                    state_nxt = S_GATE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            S_GATE: begin
                if (cnt == CNTW'(NH - 1)) begin
                    state_nxt = S_MAC_H;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            S_MAC_H: begin
                if (cnt == CNTW'(NH - 1)) begin
                    state_nxt = S_BIAS;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNTW'(1);
                end
            end
            S_BIAS:  state_nxt = S_ACT;
            S_ACT:   state_nxt = S_DONE;
            S_DONE: begin
                if (accept) begin
                    state_nxt = S_MAC_X;
                    cnt_nxt   = '0;
                end else if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane arithmetic: operands always come from the low lane group of the shifting registers
    always_comb begin
        logic signed [DATABIT-1:0] a;
        logic signed [DATABIT-1:0] b;
        logic signed [PRODW-1:0]   p;
        logic signed [PRODW-1:0]   ps;
        x_sum    = '0;
        h_sum    = '0;
        rh_lanes = '0;
        a        = '0;
        b        = '0;
        p        = '0;
        ps       = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            a     = wxh_q[l*DATABIT +: DATABIT];
            b     = xt_q[l*DATABIT +: DATABIT];
            p     = PRODW'(a) * PRODW'(b);
            x_sum = x_sum + ACCBIT'(p);

            a     = rt_q[l*DATABIT +: DATABIT];
            b     = ht1_q[l*DATABIT +: DATABIT];
            p     = PRODW'(a) * PRODW'(b);
            ps    = p >>> FRACBIT;
            rh_lanes[l*DATABIT +: DATABIT] = DATABIT'(sat_narrow(64'(ps), DATABIT));

            a     = whh_q[l*DATABIT +: DATABIT];
            b     = rh_q[l*DATABIT +: DATABIT];
            p     = PRODW'(a) * PRODW'(b);
            h_sum = h_sum + ACCBIT'(p);
        end
    end

    // Bias add and rescale back to DATABIT
    always_comb begin
        bias_sum = acc + (ACCBIT'(bh_q) <<< FRACBIT);
        bias_sh  = bias_sum >>> FRACBIT;
        pre_c    = DATABIT'(sat_narrow(64'(bias_sh), DATABIT));
    end

    gru_tanh_pwl #(
        .DATABIT (DATABIT),
        .FRACBIT (FRACBIT)
    ) u_tanh (
        .x   (pre_q),
        .y_c (tanh_c)
    );

    // Operand capture, MAC datapath and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xt_q      <= '0;
            wxh_q     <= '0;
            ht1_q     <= '0;
            rt_q      <= '0;
            whh_q     <= '0;
            rh_q      <= '0;
            bh_q      <= '0;
            acc       <= '0;
            pre_q     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                xt_q  <= xt;
                wxh_q <= wxh_in;
                ht1_q <= ht1;
                rt_q  <= rt;
                whh_q <= whh_in;
                bh_q  <= bh;
                acc   <= '0;
            end
            case (state)
                S_MAC_X: begin
                    acc   <= acc + x_sum;
                    xt_q  <= xt_q >> LW;
                    wxh_q <= wxh_q >> LW;
                end
                S_GATE: begin
                    rt_q  <= rt_q >> LW;
                    ht1_q <= ht1_q >> LW;
                    rh_q  <= (rh_q >> LW) | (HW'(rh_lanes) << (HW - LW));
                end
                S_MAC_H: begin
                    acc   <= acc + h_sum;
                    whh_q <= whh_q >> LW;
                    rh_q  <= rh_q >> LW;
                end
                S_BIAS: begin
                    pre_q <= pre_c;
                end
                S_ACT: begin
                    result    <= tanh_c;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
